// File: rtl/sm_hex_keypad.sv
// 4x4 hex keypad scanner with frame-based debounce. Each debounced press
// emits a one-cycle key_valid and shifts its code into a 32-bit digit register.
module sm_hex_keypad #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  cols,
  input  logic        clear,
  output logic [3:0]  rows,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_pressed,
  output logic [31:0] number
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, REL} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cols_meta_q, cols_sync_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]  row_q, row_d;
  logic [11:0] frame_q, frame_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  cand_q, cand_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_pressed_q, key_pressed_d;
  logic [31:0] number_q, number_d;

  logic        tick, eval, accept;
  logic [15:0] full_frame;
  logic [4:0]  low_cnt;
  logic [3:0]  low_idx;
  logic        frame_none, frame_single;

  // Scan prescaler, row pointer and capture of rows 0..2; row 3 is classified
  // straight from the synchronizer on the evaluating tick.
  always_comb begin
    tick      = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    eval      = tick && (row_q == 2'd3);
    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    row_d     = tick ? row_q + 2'd1 : row_q;
    frame_d   = frame_q;
    if (tick) begin
      case (row_q)
        2'd0:    frame_d[3:0]  = cols_sync_q;
        2'd1:    frame_d[7:4]  = cols_sync_q;
        2'd2:    frame_d[11:8] = cols_sync_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    full_frame = {cols_sync_q, frame_q};
    low_cnt    = '0;
    low_idx    = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!full_frame[i]) begin
        low_cnt = low_cnt + 5'd1;
        low_idx = 4'(i);
      end
    end
    frame_none   = (low_cnt == 5'd0);
    frame_single = (low_cnt == 5'd1);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    if (eval) begin
      case (state_q)
        IDLE: begin
          if (frame_single) begin
            cand_d  = low_idx;
            cnt_d   = 8'd1;
            state_d = DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (frame_single && (low_idx == cand_q)) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == 8'(DEBOUNCE_FRAMES)) state_d = HELD;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (frame_none) begin
            cnt_d   = 8'd1;
            state_d = REL;
          end
        end
        REL: begin
          if (frame_none) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == 8'(DEBOUNCE_FRAMES)) begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Clear and accept may coincide: the new digit survives, older ones do not.
  always_comb begin
    accept        = eval && (state_q == DEB_PRESS) && (state_d == HELD);
    key_valid_d   = accept;
    key_code_d    = accept ? cand_q : key_code_q;
    key_pressed_d = (state_d == HELD) || (state_d == REL);
    if (clear) begin
      number_d = accept ? {28'd0, cand_q} : '0;
    end else if (accept) begin
      number_d = {number_q[27:0], cand_q};
    end else begin
      number_d = number_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cols_meta_q   <= '1;
      cols_sync_q   <= '1;
      div_cnt_q     <= '0;
      row_q         <= '0;
      frame_q       <= '1;
      cnt_q         <= '0;
      cand_q        <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_pressed_q <= 1'b0;
      number_q      <= '0;
    end else begin
      cols_meta_q   <= cols;
      cols_sync_q   <= cols_meta_q;
      div_cnt_q     <= div_cnt_d;
      row_q         <= row_d;
      frame_q       <= frame_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      number_q      <= number_d;
    end
  end

  assign rows        = ~(4'b0001 << row_q);
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;
  assign number      = number_q;

endmodule

// File: tb/tb_sm_hex_keypad.sv
// Directed bench for sm_hex_keypad: a matrix model pulls a column low only while
// the row of a pressed key is driven, with SCAN_DIV=4 (16-cycle frames).
module tb_sm_hex_keypad;

  logic        clock;
  logic        resetn;
  logic [3:0]  cols;
  logic        clear;
  logic [3:0]  rows;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [31:0] number;

  logic [15:0] press_mask;
  int          n_cmp;
  int          n_err;
  int          pulses;
  int          p0;

  sm_hex_keypad #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .cols        (cols),
    .clear       (clear),
    .rows        (rows),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .number      (number)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    cols = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[4*r+c] && !rows[r]) cols[c] = 1'b0;
  end

  always @(posedge clock) begin
    #1;
    if (key_valid) pulses = pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tap(input int key, input int on_fr, input int off_fr);
    press_mask = 16'(1) << key;
    wait_cycles(on_fr * 16);
    press_mask = '0;
    wait_cycles(off_fr * 16);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_rows;
    bit         found;
    n_cmp = 0; n_err = 0; pulses = 0;
    resetn = 1'b0; clear = 1'b0; press_mask = '0;
    wait_cycles(3);
    chk("rst_rows", 32'(rows), 32'hE);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_pressed", 32'(key_pressed), 32'h0);
    chk("rst_number", number, 32'h0);

    resetn = 1'b1;
    chk("scan_r0", 32'(rows), 32'hE);
    wait_cycles(4); chk("scan_r1", 32'(rows), 32'hD);
    wait_cycles(4); chk("scan_r2", 32'(rows), 32'hB);
    wait_cycles(4); chk("scan_r3", 32'(rows), 32'h7);
    wait_cycles(4); chk("scan_wrap", 32'(rows), 32'hE);

    // Single press of 0xA, then release debounce
    p0 = pulses;
    press_mask = 16'(1) << 10;
    wait_cycles(10 * 16);
    chk("a_pulses", 32'(pulses - p0), 32'd1);
    chk("a_code", 32'(key_code), 32'hA);
    chk("a_number", number, 32'hA);
    chk("a_pressed", 32'(key_pressed), 32'h1);
    press_mask = '0;
    wait_cycles(32);
    chk("a_rel_early", 32'(key_pressed), 32'h1);
    wait_cycles(5 * 16);
    chk("a_rel_done", 32'(key_pressed), 32'h0);
    chk("a_one_pulse", 32'(pulses - p0), 32'd1);

    // Asynchronous reset mid-debounce
    tap(2, 5, 0);
    chk("pre_rst_number", number, 32'hA2);
    #2 resetn = 1'b0;
    #1;
    chk("arst_rows", 32'(rows), 32'hE);
    chk("arst_number", number, 32'h0);
    chk("arst_valid", 32'(key_valid), 32'h0);
    chk("arst_pressed", 32'(key_pressed), 32'h0);
    chk("arst_code", 32'(key_code), 32'h0);
    press_mask = '0;
    @(negedge clock);
    resetn = 1'b1;
    wait_cycles(4 * 16);

    // Digit entry 1..9
    p0 = pulses;
    for (int d = 1; d <= 9; d++) tap(d, 5, 5);
    chk("dig_number", number, 32'h23456789);
    chk("dig_pulses", 32'(pulses - p0), 32'd9);
    chk("dig_code", 32'(key_code), 32'h9);

    // Press bounce, then stable; release bounce while held
    p0 = pulses;
    for (int i = 0; i < 5; i++) begin
      press_mask = (i % 2 == 0) ? (16'(1) << 5) : '0;
      wait_cycles(6);
    end
    chk("bnc_none", 32'(pulses - p0), 32'd0);
    press_mask = 16'(1) << 5;
    wait_cycles(6 * 16);
    chk("bnc_pulse", 32'(pulses - p0), 32'd1);
    chk("bnc_code", 32'(key_code), 32'h5);
    for (int i = 0; i < 5; i++) begin
      press_mask = (i % 2 == 0) ? '0 : (16'(1) << 5);
      wait_cycles(6);
    end
    press_mask = '0;
    wait_cycles(5 * 16);
    chk("bnc_rel_pulses", 32'(pulses - p0), 32'd1);
    chk("bnc_rel_pressed", 32'(key_pressed), 32'h0);

    // Two keys together, then a key that changes mid-debounce
    p0 = pulses;
    press_mask = (16'(1) << 3) | (16'(1) << 7);
    wait_cycles(6 * 16);
    press_mask = '0;
    wait_cycles(5 * 16);
    chk("multi_none", 32'(pulses - p0), 32'd0);
    press_mask = 16'(1) << 3;
    wait_cycles(28);
    press_mask = 16'(1) << 7;
    wait_cycles(6 * 16);
    chk("swap_pulses", 32'(pulses - p0), 32'd1);
    chk("swap_code", 32'(key_code), 32'h7);
    press_mask = '0;
    wait_cycles(5 * 16);
    chk("swap_rel", 32'(key_pressed), 32'h0);

    // Clear, then rebuild 0x12345678
    pulse_clear();
    chk("clr_number", number, 32'h0);
    for (int d = 1; d <= 8; d++) tap(d, 5, 5);
    chk("clr_rebuild", number, 32'h12345678);

    // Clear coinciding with the accept of 0xF: find a frame boundary first
    found = 1'b0;
    prev_rows = rows;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (prev_rows == 4'b0111 && rows == 4'b1110) found = 1'b1;
      prev_rows = rows;
    end
    chk("frame_sync", 32'(found), 32'h1);
    p0 = pulses;
    press_mask = 16'(1) << 15;
    wait_cycles(47);
    chk("f_not_early", 32'(key_valid), 32'h0);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("f_valid", 32'(key_valid), 32'h1);
    chk("f_number", number, 32'hF);
    chk("f_code", 32'(key_code), 32'hF);
    chk("f_pressed", 32'(key_pressed), 32'h1);
    @(negedge clock);
    chk("f_valid_one", 32'(key_valid), 32'h0);
    press_mask = '0;
    wait_cycles(5 * 16);
    chk("f_pulses", 32'(pulses - p0), 32'd1);
    pulse_clear();
    chk("clr2_number", number, 32'h0);
    chk("clr2_code", 32'(key_code), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sm_hex_keypad.md
Name: sm_hex_keypad

Overview:
- Scans a 4x4 hexadecimal matrix keypad and debounces it.
- Emits one key_valid pulse with a 4-bit code per debounced press.
- Shifts each code into a 32-bit number register, which can drive sm_hex_display_8 directly.
- Serves as the input-side counterpart of the hex display path on the board top level.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven before its columns are sampled; must be >= 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-scan frames required to accept a press or a release; must be >= 2 and <= 255.

Ports:
- clock, input, 1: system clock.
- resetn, input, 1: asynchronous active-low reset.
- cols, input, 4: keypad column lines; active-low, externally pulled up; asynchronous to clock.
- clear, input, 1: synchronous clear of number.
- rows, output, 4: keypad row drive; active-low, exactly one bit low at all times.
- key_valid, output, 1: one-cycle pulse on accepted press.
- key_code, output, 4: code of the last accepted key; held between presses.
- key_pressed, output, 1: high while a key is accepted and not yet release-debounced.
- number, output, 32: shift register of entered digits; newest digit in [3:0].

Behaviour:
- One clock. Reset is asynchronous and active-low: every flop clears immediately on resetn low, independent of clock.
- Reset values:
  - rows = 4'b1110
  - key_valid = 0, key_code = 0, key_pressed = 0, number = 0
  - column synchronizer = 4'b1111, state = IDLE, all counters = 0
- Synchronizer: cols passes through 2 flops before any use.
- Prescaler: div_cnt counts 0..SCAN_DIV-1 and wraps. tick is asserted when div_cnt == SCAN_DIV-1.
- Row scan:
  - Row index r (0..3) drives rows = ~(1<<r).
  - On tick: synced cols are captured for row r, then r increments, wrapping 3->0.
  - Each row is therefore driven for exactly SCAN_DIV cycles before sampling.
- Key mapping: row r with col bit c low means key code = 4*r + c.
- Frame evaluation: on the tick sampling row 3, the 16 captured bits are classified as
  - NONE: no bit low.
  - SINGLE(k): exactly one bit low.
  - MULTI: two or more bits low; treated as NONE for press acceptance.
- State machine (advances only at frame evaluation); cnt is an 8-bit frame counter, cand is a 4-bit candidate:
  - IDLE:
    - SINGLE(k): cand = k, cnt = 1, go to DEB_PRESS.
    - Otherwise: stay.
  - DEB_PRESS:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES, go to HELD and accept.
    - Any other result: go to IDLE, cnt = 0.
  - HELD:
    - NONE: cnt = 1, go to REL.
    - Anything else (including a different key or MULTI): stay. No auto-repeat.
  - REL:
    - NONE: cnt++. When cnt reaches DEBOUNCE_FRAMES, go to IDLE.
    - Any key activity: go to HELD.
- Accept, effective the cycle after the frame-evaluation tick:
  - key_valid = 1 for exactly one cycle.
  - key_code = cand.
  - number = {number[27:0], cand}.
- key_pressed is registered and equals (state == HELD or state == REL). It rises in the same cycle as key_valid.
- clear:
  - Sets number = 0 on the next edge.
  - If clear coincides with the accept update, number = {28'b0, cand}.
  - clear does not affect scan, state, or key_code.
- Reset mid-scan or mid-debounce returns immediately to the reset values; any partial frame is discarded.
- Latency:
  - From a stable key first seen in a complete frame to key_valid: DEBOUNCE_FRAMES frames, plus 1 cycle.
  - One frame = 4*SCAN_DIV cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, so frame = 16 cycles; the keypad model pulls col c low only while row r is driven low):
- Reset: hold resetn low mid-run -> rows=1110, key_valid=0, number=0 asynchronously. After release, rows rotates 1110->1101->1011->0111 every 4 cycles.
- Single press: key 0xA (r=2, c=2) held 10 frames -> exactly one key_valid pulse, key_code=0xA, number=0x0000000A, key_pressed high until 3 key-free frames after release.
- Digit entry: press/release 1,2,3,4,5,6,7,8,9 sequentially -> number=0x23456789 after the ninth press (first digit shifted out); 9 key_valid pulses total.
- Bounce: key 5 toggling every 6 cycles for 2 frames, then stable -> no key_valid during bounce, one pulse after 3 stable frames. Release bounce within HELD -> no second pulse.
- Multi/different key:
  - keys 3 and 7 held together -> no key_valid.
  - key 3 for 2 frames, then key 7 -> no pulse for 3; pulse for 7 after 3 frames.
- Clear: number=0x12345678, assert clear -> number=0. Assert clear in the accept cycle of key 0xF -> number=0x0000000F, key_valid=1.
